tdm_demux_1x8: RTL and testbench
================================

# tdm_demux_1x8

Sequenced 1-to-8 time-division demultiplexer. Consumes one WIDTH-bit sample stream, steers consecutive samples into eight lanes (sample 0 to lane 0 … sample 7 to lane 7), and presents each completed frame as one registered 8-lane word. It is the receive-side counterpart of the 8:1 selection path in the datapath library: lane `k` here maps to mux input `i[k]` at select value `k`.

## Interface
**Parameters**
- `WIDTH`, default 1: bits per sample and per lane.

**Ports**
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sync` input 1: frame start. Qualified by `in_valid`. Marks the current sample as lane 0.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_data` input WIDTH: sample.
- `out_data` output 8*WIDTH: last accepted frame. Lane `k` is at `[k*WIDTH +: WIDTH]`.
- `out_valid` output 1: one-cycle pulse when `out_data` has been updated.
- `lane` output 3: index of the lane that the next accepted sample will fill.
- `abort` output 1: one-cycle pulse when a partial frame is discarded.
- `par_err` output 1: one-cycle pulse on parity mismatch. Driven only with the macro; tied to 0 without it.

## Operation
- **Reset.** On `rst_n` low, immediately and regardless of state:
  - state = IDLE;
  - `lane` = 0, `out_data` = 0, staging register = 0;
  - `out_valid` = `abort` = `par_err` = 0.
- **Accepted sample.** A cycle with `in_valid`=1. Cycles with `in_valid`=0 change nothing: lane and staging hold, and gaps of any length are allowed.
- **IDLE.** Accepted samples without `sync` are ignored. On an accepted sample with `sync`: write staging lane 0, set `lane` to 1, go to FILL.
- **FILL, no `sync`.** Write staging[`lane`], then increment `lane`.
- **FILL, on writing lane 7:**
  - Without macro: copy staging plus the lane-7 sample to `out_data`, pulse `out_valid`, set `lane` to 0, stay in FILL. Frames stream back-to-back without further `sync`.
  - With macro: set `lane` to 0 and go to PAR.
- **PAR (macro only).** The next accepted sample is the parity word.
  - Expected parity is the bitwise XOR of the eight lane samples.
  - Match: update `out_data` and pulse `out_valid`.
  - Mismatch: leave `out_data` unchanged and pulse `par_err`.
  - Either way, return to FILL at lane 0.
- **`sync` inside a frame.** Applies to an accepted sample with `sync` in FILL with `lane`≠0, or in PAR.
  - Discard the partial frame and pulse `abort`.
  - Store the sample as lane 0, set `lane` to 1, stay in or return to FILL.
  - `out_data` is unchanged.
- **`sync` at a frame boundary.** `sync` in FILL with `lane`=0 is a normal frame start: no abort.
- **Stale staging.** Staging is not cleared between frames. Every lane is rewritten before it can be published.

## Timing
- All outputs are registered.
- `out_valid`, `abort` and `par_err` assert in the cycle after the sampling edge of the triggering sample, for exactly one cycle.
- `lane` reflects the post-edge value.
- Latency from the last lane sample (or the parity sample) to `out_data`/`out_valid`: 1 cycle.
- Throughput at full rate: one frame per 8 cycles without the macro, one frame per 9 cycles with it.
- `out_valid` and `abort` can never assert in the same cycle.
- `par_err` and `out_valid` are mutually exclusive.
- Reset asserted mid-frame discards all state asynchronously. After deassertion the block waits in IDLE for `sync`.

## Configuration
- Macro: `TDM_DEMUX_PARITY_EN`.
- Defined: the PAR state exists, each frame is 8 data samples plus 1 parity sample, and `par_err` is live.
- Undefined: there is no PAR state, frames are 8 samples, and `par_err` is the constant 0.

## Test plan
- **Reset and IDLE.** With `WIDTH`=1, assert `rst_n` low at `lane`=4 mid-frame. Then drive 5 samples with no `sync`. Required: all outputs are 0 during reset and stay 0 afterwards, with `lane` at 0 and no `out_valid`.
- **Basic frame.** Apply `sync` plus samples 1,0,1,1,0,0,1,0 (lane 0 first) on consecutive cycles. Required: `out_data`=8'h4D and a one-cycle `out_valid` one cycle after the 8th sample; `lane` returns to 0.
- **Bubbles and streaming.** Repeat the frame with `in_valid` low for 3 cycles after samples 2 and 6. Then send a second frame 0xFF (samples all 1) with no `sync`. Required: 8'h4D and then 8'hFF, each with a single `out_valid` pulse.
- **Mid-frame sync.** After a 0x4D frame, send 5 samples, then `sync` with sample 1 followed by 7 zeros. Required: `abort` pulses once with `out_data` still 0x4D; then `out_data`=8'h01 with `out_valid`.
- **Parity (macro, `WIDTH`=8).**
  - Send lanes 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80, then parity 0xFF. Required: `out_valid` and `out_data`=64'h8040201008040201.
  - Repeat with parity 0xFE. Required: `par_err` pulses and `out_data` is unchanged.
- **Sync in PAR (macro).** Apply `sync` on the parity slot. Required: `abort` pulses, there is no `out_valid` or `par_err`, and `lane` is 1.

Source files
------------

// File: rtl/tdm_demux_1x8.sv
// Sequenced 1-to-8 TDM demultiplexer: steers a sample stream into eight lanes
// and publishes each completed frame as one registered word. Optional parity
// slot per frame is enabled with the TDM_DEMUX_PARITY_EN macro.
module tdm_demux_1x8 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic [8*WIDTH-1:0]   out_data,
    output logic                 out_valid,
    output logic [2:0]           lane,
    output logic                 abort,
    output logic                 par_err
);

`ifdef TDM_DEMUX_PARITY_EN
    typedef enum logic [1:0] {IDLE, FILL, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL} state_t;
`endif

    state_t                  state, state_d;
    logic [2:0]              lane_d;
    logic [7:0][WIDTH-1:0]   staging, stage_d;
    logic                    wr_en;
    logic [2:0]              wr_lane;
    logic                    publish;
    logic                    abort_d;

`ifdef TDM_DEMUX_PARITY_EN
    logic                    par_err_d;
    logic                    par_err_q;
    logic [WIDTH-1:0]        parity;

    always_comb begin
        parity = '0;
        for (int k = 0; k < 8; k++) parity ^= staging[k];
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lane  <= 3'd0;
        end else begin
            state <= state_d;
            lane  <= lane_d;
        end
    end

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state;
        lane_d  = lane;
        wr_en   = 1'b0;
        wr_lane = lane;
        publish = 1'b0;
        abort_d = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (sync) begin
                        wr_en   = 1'b1;
                        wr_lane = 3'd0;
                        lane_d  = 3'd1;
                        state_d = FILL;
                    end
                end
                FILL: begin
                    wr_en = 1'b1;
                    if (sync && lane != 3'd0) begin
                        abort_d = 1'b1;
                        wr_lane = 3'd0;
                        lane_d  = 3'd1;
                    end else begin
                        // lane wraps 7 -> 0 naturally; a sync at lane 0 is an ordinary frame start
                        lane_d = lane + 3'd1;
                        if (lane == 3'd7) begin
`ifdef TDM_DEMUX_PARITY_EN
                            state_d = PAR;
`else
                            publish = 1'b1;
`endif
                        end
                    end
                end
`ifdef TDM_DEMUX_PARITY_EN
                PAR: begin
                    state_d = FILL;
                    if (sync) begin
                        abort_d = 1'b1;
                        wr_en   = 1'b1;
                        wr_lane = 3'd0;
                        lane_d  = 3'd1;
                    end else if (in_data == parity) begin
                        publish = 1'b1;
                        lane_d  = 3'd0;
                    end else begin
                        par_err_d = 1'b1;
                        lane_d    = 3'd0;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Staging with the current sample merged in, so the lane-7 write and the publish share one edge.
    always_comb begin
        stage_d = staging;
        if (wr_en) stage_d[wr_lane] = in_data;
    end

    // NOTE: staging is reset explicitly so a cleared block never publishes undefined lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            abort     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            staging   <= stage_d;
            out_valid <= publish;
            abort     <= abort_d;
            if (publish) out_data <= stage_d;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Self-checking bench for tdm_demux_1x8: directed cases plus randomized traffic
// compared every cycle against a frame-queue reference model.
module tb_tdm_demux_1x8;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 9;
`else
    localparam int WIDTH     = 1;
    localparam int FRAME_LEN = 8;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                sync;
    logic                in_valid;
    logic [WIDTH-1:0]    in_data;
    logic [8*WIDTH-1:0]  out_data;
    logic                out_valid;
    logic [2:0]          lane;
    logic                abort;
    logic                par_err;

    tdm_demux_1x8 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(in_valid),
        .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
        .lane(lane), .abort(abort), .par_err(par_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: a frame is just the list of samples gathered since the last sync.
    logic [WIDTH-1:0]    frame[$];
    bit                  in_frame;
    logic [8*WIDTH-1:0]  exp_data;
    bit                  exp_valid, exp_abort, exp_perr;

    task automatic model_reset();
        frame.delete();
        in_frame  = 0;
        exp_data  = '0;
        exp_valid = 0;
        exp_abort = 0;
        exp_perr  = 0;
    endtask

    function automatic logic [WIDTH-1:0] frame_parity();
        logic [WIDTH-1:0] p = '0;
        for (int i = 0; i < 8; i++) p ^= frame[i];
        return p;
    endfunction

    task automatic model_step(input bit v, input bit s, input logic [WIDTH-1:0] d);
        exp_valid = 0;
        exp_abort = 0;
        exp_perr  = 0;
        if (!v) return;
        if (s) begin
            if (in_frame && frame.size() != 0) exp_abort = 1;
            frame.delete();
            frame.push_back(d);
            in_frame = 1;
        end else if (in_frame) begin
            frame.push_back(d);
        end
        if (frame.size() == FRAME_LEN) begin
            bit ok = 1;
`ifdef TDM_DEMUX_PARITY_EN
            ok = (frame[8] == frame_parity());
`endif
            if (ok) begin
                for (int i = 0; i < 8; i++) exp_data[i*WIDTH +: WIDTH] = frame[i];
                exp_valid = 1;
            end else begin
                exp_perr = 1;
            end
            frame.delete();
        end
    endtask

    // One clock: drive inputs, let the edge happen, then compare all outputs against the model.
    task automatic step(input bit v, input bit s, input logic [WIDTH-1:0] d);
        in_valid = v;
        sync     = s;
        in_data  = d;
        @(posedge clk);
        if (rst_n) model_step(v, s, d);
        #1;
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("abort",     64'(abort),     64'(exp_abort));
        check("par_err",   64'(par_err),   64'(exp_perr));
        check("lane",      64'(lane),      64'(frame.size() % 8));
        check("out_data",  64'(out_data),  64'(exp_data));
    endtask

`ifndef TDM_DEMUX_PARITY_EN
    // Sends eight 1-bit samples (lane 0 first), optionally with 3-cycle bubbles after samples 2 and 6.
    task automatic send_frame(input logic [7:0] pat, input bit with_sync, input bit bubbles);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, with_sync && i == 0, WIDTH'(pat[i]));
            if (bubbles && (i == 1 || i == 5))
                repeat (3) step(1'b0, 1'b1, WIDTH'($urandom));
        end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        sync     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_lane", 64'(lane), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;

        // Reset mid-frame at lane 4, then no-sync samples must stay ignored
        step(1'b1, 1'b1, WIDTH'(1));
        step(1'b1, 1'b0, WIDTH'(0));
        step(1'b1, 1'b0, WIDTH'(1));
        step(1'b1, 1'b0, WIDTH'(1));
        check("pre_rst_lane", 64'(lane), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_lane",  64'(lane), 64'd0);
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_abort", 64'(abort), 64'd0);
        check("async_rst_perr",  64'(par_err), 64'd0);
        check("async_rst_data",  64'(out_data), 64'd0);
        step(1'b1, 1'b1, WIDTH'(1));
        step(1'b1, 1'b0, WIDTH'(1));
        rst_n = 1'b1;
        repeat (5) step(1'b1, 1'b0, WIDTH'(1));
        check("idle_lane", 64'(lane), 64'd0);

`ifndef TDM_DEMUX_PARITY_EN
        // Basic frame
        send_frame(8'h4D, 1'b1, 1'b0);
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_data",  64'(out_data), 64'h4D);
        check("basic_lane",  64'(lane), 64'd0);
        step(1'b0, 1'b0, '0);
        check("basic_pulse_len", 64'(out_valid), 64'd0);

        // Bubbles, then streamed frame without sync
        send_frame(8'h4D, 1'b1, 1'b1);
        check("bubble_data", 64'(out_data), 64'h4D);
        send_frame(8'hFF, 1'b0, 1'b0);
        check("stream_valid", 64'(out_valid), 64'd1);
        check("stream_data",  64'(out_data), 64'hFF);

        // Mid-frame sync
        send_frame(8'h4D, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(i & 1));
        step(1'b1, 1'b1, WIDTH'(1));
        check("mid_abort", 64'(abort), 64'd1);
        check("mid_hold",  64'(out_data), 64'h4D);
        check("mid_lane",  64'(lane), 64'd1);
        repeat (7) step(1'b1, 1'b0, WIDTH'(0));
        check("mid_valid", 64'(out_valid), 64'd1);
        check("mid_data",  64'(out_data), 64'h01);
`else
        // Good parity
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, WIDTH'(1 << i));
        check("par_slot_lane", 64'(lane), 64'd0);
        step(1'b1, 1'b0, WIDTH'(8'hFF));
        check("par_ok_valid", 64'(out_valid), 64'd1);
        check("par_ok_data",  64'(out_data), 64'h8040201008040201);

        // Bad parity
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, WIDTH'(1 << i));
        step(1'b1, 1'b0, WIDTH'(8'hFE));
        check("par_bad_err",   64'(par_err), 64'd1);
        check("par_bad_valid", 64'(out_valid), 64'd0);
        check("par_bad_hold",  64'(out_data), 64'h8040201008040201);

        // Sync on the parity slot
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, WIDTH'(8'h11 * i));
        step(1'b1, 1'b1, WIDTH'(8'h5A));
        check("par_sync_abort", 64'(abort), 64'd1);
        check("par_sync_valid", 64'(out_valid), 64'd0);
        check("par_sync_perr",  64'(par_err), 64'd0);
        check("par_sync_lane",  64'(lane), 64'd1);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit               v = ($urandom_range(9) < 7);
            bit               s = ($urandom_range(19) == 0);
            logic [WIDTH-1:0] d = WIDTH'($urandom);
`ifdef TDM_DEMUX_PARITY_EN
            if (frame.size() == 8 && !s && $urandom_range(1) == 1) d = frame_parity();
`endif
            step(v, s, d);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
